// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, iterative-shifter state encoding and shift-op codes.
package alu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic SH_SRL = 1'b0;
  localparam logic SH_SRA = 1'b1;

endpackage

// File: rtl/sr_step.sv
// One bounded right-shift slice: shifts data right by amt (0..STEP) with a chosen fill bit.
module sr_step
  import alu_pkg::*;
#(
  parameter int unsigned STEP = 4,
  parameter int unsigned AW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amt,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  // Prepending the fill bit lets a single arithmetic shift cover both srl and sra.
  assign q = WIDTH'($signed({fill, data}) >>> amt);

endmodule

// File: rtl/sr32_iter.sv
// Multicycle srl/sra unit: shifts B right by A[4:0], at most STEP bits per cycle, start/done handshake.
module sr32_iter
  import alu_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             arith,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned AW = $clog2(STEP + 1);
  localparam int unsigned CW = SHW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] data_q, shifted;
  logic [SHW-1:0]   cnt_q;
  logic             arith_q;
  logic [AW-1:0]    amt;
  logic             last, fill;
  logic             load, load_zero, step_en, res_from_step;
  logic             ready_nx, busy_nx, done_nx;
  logic             unused_a_hi;

  assign unused_a_hi = ^A[WIDTH-1:SHW];

  // Final iteration once the remaining count fits in one step.
  always_comb begin
    last = ({1'b0, cnt_q} <= STEP_C);
    amt  = last ? AW'(cnt_q) : AW'(STEP);
    fill = arith_q & data_q[WIDTH-1];
  end

  sr_step #(.STEP(STEP), .AW(AW)) u_step (
    .data (data_q),
    .amt  (amt),
    .fill (fill),
    .q    (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nx;
      ready   <= ready_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:    if (start && !flush) state_nx = (A[SHW-1:0] == '0) ? DONE : SHIFT;
      SHIFT:   if (flush) state_nx = IDLE;
               else if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status flags are registered copies of the next-state decode; datapath enables follow the current state.
  always_comb begin
    ready_nx      = (state_nx == IDLE);
    busy_nx       = (state_nx == SHIFT) || (state_nx == DONE);
    done_nx       = (state_nx == DONE);
    load          = (state_q == IDLE) && start && !flush;
    load_zero     = load && (A[SHW-1:0] == '0);
    step_en       = (state_q == SHIFT) && !flush;
    res_from_step = step_en && last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
      res     <= '0;
    end else begin
      if (load) begin
        data_q  <= B;
        cnt_q   <= A[SHW-1:0];
        arith_q <= arith;
      end else if (step_en) begin
        data_q <= shifted;
        cnt_q  <= last ? '0 : cnt_q - SHW'(STEP);
      end
      if (load_zero) res <= B;
      else if (res_from_step) res <= shifted;
    end
  end

endmodule

// File: tb/tb_sr32_iter.sv
// Directed bench for sr32_iter with STEP=4: latency, results, handshake, flush and async reset.
module tb_sr32_iter;
  import alu_pkg::*;

  logic        clk, rst, start, flush, arith;
  logic [31:0] A, B;
  logic        ready, busy, done;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  sr32_iter #(.STEP(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .arith (arith),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and waits for done; lat counts cycles from the start edge, capped at 60.
  task automatic run_op(input logic ar, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc);
    arith = ar; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    int lat, bc;
    rst = 1'b1; start = 1'b0; flush = 1'b0; arith = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b want 100", {ready, busy, done}); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 00000000", res); end
    run_op(SH_SRL, 32'd31, 32'h8000_0000, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("FAIL srl31_latency got %0d want 9", lat); end
    checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL srl31_res got %h want 00000001", res); end
    checks++; if (bc !== 9) begin errors++; $display("FAIL srl31_busy got %0d want 9", bc); end
    tick();
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL srl31_idle got %b want 100", {ready, busy, done}); end
  endtask

  task automatic test_sra();
    int lat, bc;
    run_op(SH_SRA, 32'd4, 32'h8000_0000, lat, bc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sra4_latency got %0d want 2", lat); end
    checks++; if (res !== 32'hF800_0000) begin errors++; $display("FAIL sra4_res got %h want F8000000", res); end
    tick();
    run_op(SH_SRA, 32'd31, 32'h8000_0000, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("FAIL sra31_latency got %0d want 9", lat); end
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_res got %h want FFFFFFFF", res); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    arith = SH_SRL; A = 32'd0; B = 32'h1234_5678; start = 1'b1;
    tick();
    checks++; if (done !== 1'b1 || res !== 32'h1234_5678) begin errors++; $display("FAIL zero_shift got done=%b res=%h want done=1 res=12345678", done, res); end
    A = 32'd4; B = 32'hAAAA_5555;
    tick();
    checks++; if ({ready, busy, done} !== 3'b100 || res !== 32'h1234_5678) begin errors++; $display("FAIL b2b_ignored got flags=%b res=%h want 100 12345678", {ready, busy, done}, res); end
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    lat = 1;
    while (!done && lat < 60) begin tick(); lat++; end
    checks++; if (lat !== 2 || res !== 32'h0AAA_A555) begin errors++; $display("FAIL b2b_second got lat=%0d res=%h want 2 0AAAA555", lat, res); end
    tick();
  endtask

  task automatic test_upper_ignored();
    int lat, bc;
    run_op(SH_SRL, 32'hFFFF_FFE3, 32'hF0F0_F0F0, lat, bc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL upper_bits_latency got %0d want 2", lat); end
    checks++; if (res !== 32'h1E1E_1E1E) begin errors++; $display("FAIL upper_bits_res got %h want 1E1E1E1E", res); end
    tick();
  endtask

  task automatic test_flush();
    int pulses = 0;
    arith = SH_SRL; A = 32'd20; B = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 32'd1; B = 32'h0000_0000; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b1;
    if (done) pulses++;
    tick();
    flush = 1'b0;
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL flush_idle got %b want 100", {ready, busy, done}); end
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", pulses); end
    checks++; if (res !== 32'h1E1E_1E1E) begin errors++; $display("FAIL flush_res_kept got %h want 1E1E1E1E", res); end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    arith = SH_SRA; A = 32'd31; B = 32'h8000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL async_rst_flags got %b want 100", {ready, busy, done}); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL async_rst_res got %h want 00000000", res); end
    tick();
    rst = 1'b0;
    tick();
    run_op(SH_SRL, 32'd8, 32'h0000_0100, lat, bc);
    checks++; if (lat !== 3 || res !== 32'h0000_0001) begin errors++; $display("FAIL post_rst_op got lat=%0d res=%h want 3 00000001", lat, res); end
    tick();
  endtask

  task automatic test_sweep();
    int lat, bc, exp_lat;
    logic [31:0] b, a, exp;
    for (int ar = 0; ar < 2; ar++) begin
      for (int s = 0; s < 32; s++) begin
        b = $urandom();
        if (s[0]) b[31] = 1'b1;
        a = {27'($urandom()), 5'(s)};
        if (ar == 1) exp = $signed(b) >>> s;
        else exp = b >> s;
        exp_lat = (s + 3) / 4 + 1;
        run_op(1'(ar), a, b, lat, bc);
        checks++; if (res !== exp) begin errors++; $display("FAIL sweep_res ar=%0d s=%0d b=%h got %h want %h", ar, s, b, res, exp); end
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sweep_latency ar=%0d s=%0d got %0d want %0d", ar, s, lat, exp_lat); end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_back_to_back();
    test_upper_ignored();
    test_flush();
    test_async_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr32_iter.md
Name: sr32_iter

Overview:
- Multicycle logical/arithmetic right shifter for the EX stage.
- Complements the combinational left shifter: same operand convention, with `A[4:0]` as the shift amount and `B` as the data.
- Shifts `STEP` bits per cycle under a start/done handshake. This trades latency for area and timing on `srl`/`sra`/`srlv`/`srav`.
- The hazard unit stalls on `busy` and cancels with `flush`.

Parameters:
- WIDTH, 32, data width; fixed at 32 in this design.
- SHW, 5, shift-amount width, equal to log2(WIDTH).
- STEP, 4, maximum bits shifted per cycle; legal range 1..WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when `ready`=1.
- flush  in  1  synchronous cancel from the pipeline.
- arith  in  1  1 = `sra` (sign fill), 0 = `srl` (zero fill).
- A  in  32  shift amount; only `A[4:0]` is used, `A[31:5]` is ignored.
- B  in  32  data to shift.
- ready  out  1  1 iff state is IDLE.
- busy  out  1  1 iff state is SHIFT or DONE.
- done  out  1  one-cycle pulse; `res` is valid from this cycle on.
- res  out  32  result register.

Behaviour:
- Reset (async, any state): state=IDLE, `res`=0, internal data/count/arith cleared, `done`=0, `ready`=1, `busy`=0.
- States: IDLE, SHIFT, DONE. Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- IDLE, `start`=1, `flush`=0 (edge k):
  - Latch data=`B`, cnt=`A[4:0]`, arith.
  - If `A[4:0]`=0: go to DONE with `res`=`B`.
  - Otherwise: go to SHIFT.
- SHIFT, each edge:
  - If cnt>STEP: data shifted right by STEP, cnt-=STEP.
  - Otherwise: data shifted right by cnt, cnt=0, go to DONE, and `res` is loaded with the final shifted value at the same edge.
  - Fill bit is `data[31]` of the latched operand when arith=1, else 0.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - N = ceil(`A[4:0]`/STEP).
  - `done` is high in the cycle after edge k+N.
  - Defaults: shamt 0 → `done` 1 cycle after the start edge; shamt 31 → 9 cycles.
- `res` holds its last value until the next DONE entry. It is unaffected by IDLE, `start`, or `flush`.
- `start` while `ready`=0 (SHIFT or DONE): ignored. No queueing and no operand update.
- `flush`=1 in SHIFT: go to IDLE next edge, no `done`, `res` unchanged.
- `flush`=1 in DONE: `done` still pulses; `flush` has no effect there.
- `flush` and `start` together in IDLE: `flush` wins, stay IDLE.
- `rst` asserted mid-operation: immediate return to reset values; the operation is lost.
- Arithmetic:
  - `sra` of a negative value saturates to 0xFFFFFFFF at shamt 31.
  - `srl` yields `B` >> shamt exactly.
  - Results are bit-identical to single-cycle `>>` / `>>>`.

Decomposition:
- Shared package `alu_pkg`:
  - State encodings IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Constants WIDTH=32 and SHW=5.
  - Shift-op codes SH_SRL=1'b0 and SH_SRA=1'b1, for use by this block and the ALU decoder.
- One combinational sub-module, `sr_step`, built around a single `>>`/`>>>`-style slice:
  - Inputs: data[31:0], amt (0..STEP), fill.
  - Output: data shifted right by amt, filled with fill.
- `sr32_iter` holds the FSM, counter and registers.

Test Plan (STEP=4):
1. Reset check: `rst` pulse → `ready`=1, `busy`=0, `done`=0, `res`=0. Then `srl`, B=0x80000000, A=31 → `done` 9 cycles after the start edge (N=8), `res`=0x00000001, `busy` high for 9 cycles.
2. `sra`, B=0x80000000, A=4 → `done` 2 cycles after start, `res`=0xF8000000. Then `sra` B=0x80000000, A=31 → `res`=0xFFFFFFFF.
3. B=0x12345678, A=0 → `done` 1 cycle after start, `res`=0x12345678. Back-to-back `start` held high → second op accepted only after return to IDLE.
4. `srl`, B=0xF0F0F0F0, A=0xFFFFFFE3 (shamt 3, upper bits ignored) → N=1, `res`=0x1E1E1E1E.
5. `srl` B=0xFFFFFFFF, A=20; `start` again with new operands in cycle 2 (ignored); `flush` in cycle 3 → IDLE next edge, no `done`, `res` keeps its prior value.
6. Async `rst` asserted mid-SHIFT, between clock edges → outputs reset immediately without a clock edge. A new op after release (B=0x00000100, A=8, `srl`) → `res`=0x00000001 with normal latency.
7. Random sweep: all shamt 0..31 × both `arith` values × random B, compared against a reference model; latency checked as ceil(shamt/4)+1 cycles from the start edge.
